// File: rtl/key_step_pulse_if.sv
// key_step_pulse_if
//   Groups the key input and the three debounced outputs of key_step_pulse.
//   Ports:
//     iKey     - raw push-button level, asynchronous to the system clock
//     oLevel   - debounced key level
//     oPulse   - one-cycle step pulse (press, plus repeats when enabled)
//     oRelease - one-cycle pulse on an accepted release
//   Modports:
//     master - drives the key and observes the outputs (button side / bench)
//     slave  - the debouncer itself
interface key_step_pulse_if;
    logic iKey;
    logic oLevel;
    logic oPulse;
    logic oRelease;

    modport master (output iKey, input oLevel, input oPulse, input oRelease);
    modport slave  (input iKey, output oLevel, output oPulse, output oRelease);
endinterface

// File: rtl/key_step_pulse.sv
// key_step_pulse
//   Synchronizes a raw push-button, debounces it with a four-state FSM and
//   emits a one-cycle step pulse for the downstream 3-bit counter, plus the
//   debounced level and a one-cycle release pulse. All outputs are registered.
//   Optional feature macro: KEY_AUTOREPEAT_EN
//     defined   - while the key stays held, extra step pulses fire
//                 REPEAT_DELAY cycles after the press pulse, then every
//                 REPEAT_PERIOD cycles.
//     undefined - exactly one step pulse per accepted press.
//   Ports:
//     CLK   - system clock, rising edge
//     rst_n - asynchronous active-low reset
//     key   - key_step_pulse_if.slave (iKey in; oLevel, oPulse, oRelease out)
module key_step_pulse #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic            CLK,
    input  logic            rst_n,
    key_step_pulse_if.slave key
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);

    // Elaboration-time sanity check on the configuration.
    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("key_step_pulse: illegal parameter value");
    end

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   release_q, release_d;
    logic                   key_sync;

`ifdef KEY_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] REP_DELAY  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_PERIOD = RW'(REPEAT_PERIOD);

    // rep_cnt counts PRESSED cycles since the last step pulse; rep_armed
    // marks that the first (delayed) repeat has already fired.
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_armed_q, rep_armed_d;
    logic [RW-1:0] rep_next;
    logic [RW-1:0] rep_target;
`endif

    // The FSM only ever looks at the last synchronizer flop.
    assign sync_d   = {sync_q[SYNC_STAGES-2:0], key.iKey};
    assign key_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        pulse_d   = 1'b0;
        release_d = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        rep_next    = rep_cnt_q + RW'(1);
        rep_target  = rep_armed_q ? REP_PERIOD : REP_DELAY;
`endif
        case (state_q)
            IDLE: begin
                level_d = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
                rep_cnt_d   = '0;
                rep_armed_d = 1'b0;
`endif
                if (key_sync) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!key_sync) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_DONE) begin
                    state_d = PRESSED;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                    rep_cnt_d   = '0;
                    rep_armed_d = 1'b0;
`endif
                end else begin
                    // cnt_q < CNT_DONE here, so the increment cannot wrap.
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESSED: begin
                if (!key_sync) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CW'(1);
                end
`ifdef KEY_AUTOREPEAT_EN
                else if (rep_next == rep_target) begin
                    pulse_d     = 1'b1;
                    rep_cnt_d   = '0;
                    rep_armed_d = 1'b1;
                end else begin
                    rep_cnt_d = rep_next;
                end
`endif
            end
            RELEASE_WAIT: begin
                // Repeat counter is deliberately left frozen here.
                if (key_sync) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_DONE) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            pulse_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            release_q <= release_d;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
        end
    end
`endif

    assign key.oLevel   = level_q;
    assign key.oPulse   = pulse_q;
    assign key.oRelease = release_q;

endmodule

// File: tb/tb_key_step_pulse.sv
// tb_key_step_pulse
//   Scoreboard bench for key_step_pulse. Each stimulus step predicts the
//   outputs after the coming clock edge from a run-length model of the key
//   (a level flips once the synchronized key has disagreed with it for D+1
//   consecutive FSM samples) and queues the prediction; a monitor pops and
//   compares after every edge. Directed scenarios also check absolute pulse
//   edges against the S+D latency.
module tb_key_step_pulse;
    localparam int S  = 2;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic CLK   = 1'b0;
    logic rst_n = 1'b0;

    key_step_pulse_if kif ();

    key_step_pulse #(
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .CLK  (CLK),
        .rst_n(rst_n),
        .key  (kif)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic lvl;
        logic pls;
        logic rel;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_edge = 0;
    int   pulse_edges[$];
    int   rel_edges[$];

    logic [S-1:0] m_hist = '0;
    logic         m_lvl  = 1'b0;
    int           m_run  = 0;
    int           m_rc   = 0;
    logic         m_armed = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
    endtask

    // Monitor: sample #1 after each edge, log pulse edges, compare.
    always @(posedge CLK) begin
        exp_t e;
        exp_t a;
        #1;
        if (kif.oPulse === 1'b1)   pulse_edges.push_back(cyc);
        if (kif.oRelease === 1'b1) rel_edges.push_back(cyc);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {kif.oLevel, kif.oPulse, kif.oRelease};
            chk($sformatf("sb_edge%0d(lvl,pls,rel)", cyc), int'(a), int'(e));
        end
    end

    // One clock of stimulus; predicts the outputs after the next edge.
    task automatic step(input logic k, input logic r);
        logic x;
        exp_t e;
        @(negedge CLK);
        kif.iKey  = k;
        rst_n     = r;
        last_edge = cyc + 1;
        e = '0;
        if (!r) begin
            m_hist  = '0;
            m_lvl   = 1'b0;
            m_run   = 0;
            m_rc    = 0;
            m_armed = 1'b0;
        end else begin
            // value the FSM sees at this edge: key sampled S edges earlier
            x = m_hist[S-1];
            m_hist = {m_hist[S-2:0], k};
`ifdef KEY_AUTOREPEAT_EN
            if (m_lvl && m_run == 0 && x) begin
                m_rc++;
                if (m_rc == (m_armed ? RP : RD)) begin
                    e.pls   = 1'b1;
                    m_rc    = 0;
                    m_armed = 1'b1;
                end
            end
`endif
            if (x != m_lvl) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_lvl = ~m_lvl;
                    m_run = 0;
                    if (m_lvl) begin
                        e.pls   = 1'b1;
                        m_rc    = 0;
                        m_armed = 1'b0;
                    end else begin
                        e.rel = 1'b1;
                    end
                end
            end else begin
                m_run = 0;
            end
        end
        e.lvl = m_lvl;
        exp_q.push_back(e);
    endtask

    task automatic run(input logic k, input int n);
        repeat (n) step(k, 1'b1);
    endtask

    task automatic settle();
        @(posedge CLK);
        #2;
    endtask

    task automatic clr();
        pulse_edges.delete();
        rel_edges.delete();
    endtask

    function automatic int first_of(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    function automatic int last_of(input int q[$]);
        return (q.size() > 0) ? q[q.size()-1] : -1;
    endfunction

    initial begin
        int t;
        int t2;
        int n_rep;
        kif.iKey = 1'b0;
        repeat (3) step(1'b0, 1'b0);
        settle();
        chk("reset_outputs", int'({kif.oLevel, kif.oPulse, kif.oRelease}), 0);

        // 1: clean press, then clean release
        run(1'b0, 5);
        clr();
        step(1'b1, 1'b1); t = last_edge;
        run(1'b1, 29);
        settle();
        chk("s1_npulse", pulse_edges.size(), 1);
        chk("s1_pulse_edge", first_of(pulse_edges), t + S + D);
        chk("s1_nrel_hold", rel_edges.size(), 0);
        chk("s1_level_held", int'(kif.oLevel), 1);
        clr();
        step(1'b0, 1'b1); t = last_edge;
        run(1'b0, 9);
        settle();
        chk("s1_nrel", rel_edges.size(), 1);
        chk("s1_rel_edge", first_of(rel_edges), t + S + D);
        chk("s1_npulse_rel", pulse_edges.size(), 0);

        // 2: bounce, then a stable press
        clr();
        for (int i = 0; i < 8; i++) step((i % 2) == 0, 1'b1);
        step(1'b1, 1'b1); t = last_edge;
        run(1'b1, 14);
        settle();
        chk("s2_npulse", pulse_edges.size(), 1);
        chk("s2_pulse_edge", first_of(pulse_edges), t + S + D);
        run(1'b0, 12);

        // 3: glitch shorter than the debounce window
        clr();
        run(1'b1, 3);
        run(1'b0, 12);
        settle();
        chk("s3_npulse", pulse_edges.size(), 0);
        chk("s3_nrel", rel_edges.size(), 0);
        chk("s3_level", int'(kif.oLevel), 0);

        // 4: release glitch, then a true release
        clr();
        run(1'b1, 12);
        run(1'b0, 2);
        run(1'b1, 12);
        settle();
        chk("s4_npulse", pulse_edges.size(), 1);
        chk("s4_nrel_glitch", rel_edges.size(), 0);
        step(1'b0, 1'b1); t = last_edge;
        run(1'b0, 11);
        settle();
        chk("s4_nrel", rel_edges.size(), 1);
        chk("s4_rel_edge", first_of(rel_edges), t + S + D);
        chk("s4_npulse_total", pulse_edges.size(), 1);

        // 5: reset inside PRESS_WAIT with the key still held
        run(1'b0, 5);
        clr();
        step(1'b1, 1'b1); t = last_edge;
        repeat (3) step(1'b1, 1'b1);
        repeat (6) step(1'b1, 1'b0);
        settle();
        chk("s5_outputs_in_reset", int'({kif.oLevel, kif.oPulse, kif.oRelease}), 0);
        step(1'b1, 1'b1); t2 = last_edge;
        run(1'b1, 14);
        settle();
        chk("s5_npulse", pulse_edges.size(), 1);
        chk("s5_pulse_edge", first_of(pulse_edges), t2 + S + D);
        chk("s5_restart_edge", t2, t + 10);
        run(1'b0, 12);

        // 6: long hold (auto-repeat when the feature is built in)
        clr();
        step(1'b1, 1'b1); t = last_edge;
        run(1'b1, 44);
        settle();
`ifdef KEY_AUTOREPEAT_EN
        n_rep = 7;
        chk("s6_last_pulse_edge", last_of(pulse_edges), t + S + D + RD + 5 * RP);
`else
        n_rep = 1;
        chk("s6_last_pulse_edge", last_of(pulse_edges), t + S + D);
`endif
        chk("s6_npulse", pulse_edges.size(), n_rep);
        chk("s6_first_pulse_edge", first_of(pulse_edges), t + S + D);
        run(1'b0, 12);

        // Randomized bursts with occasional resets
        for (int b = 0; b < 200; b++) begin
            if ($urandom_range(0, 39) == 0) begin
                repeat ($urandom_range(1, 3)) step(1'($urandom_range(0, 1)), 1'b0);
            end
            run(1'($urandom_range(0, 1)), $urandom_range(1, 10));
        end
        run(1'b0, 12);
        settle();
        chk("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time bound in case the clock or a loop stalls.
    initial begin
        #2_000_000;
        $display("FAIL timeout: sim time exceeded, want finish before bound");
        $fatal(1, "timeout");
    end

endmodule
